// File: rtl/door_motor_driver.sv
// rtl/door_motor_driver.sv - H-bridge driver with dead time, position tracking and limits; DOOR_MOTOR_BRAKE_EN adds a BRAKE state
module door_motor_driver #(
  parameter int STEP_DIV    = 500000,
  parameter int TRAVEL      = 200,
  parameter int DEAD_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] motor_cmd,
  output logic       in_a,
  output logic       in_b,
  output logic [7:0] pos,
  output logic       limit_closed,
  output logic       limit_open,
  output logic       busy,
  output logic       fault
);

  localparam int SW = $clog2(STEP_DIV + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [7:0]    POS_MAX   = 8'(TRAVEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAD,
    S_DRIVE_OPEN,
    S_DRIVE_CLOSE,
`ifdef DOOR_MOTOR_BRAKE_EN
    S_BRAKE,
`endif
    S_FAULT
  } state_t;

  state_t        state, state_d;
  logic [1:0]    cmd_q;
  logic          dir, dir_d;            // 1 = open, 0 = close
  logic [DW-1:0] dead_cnt, dead_cnt_d;  // shared by DEAD and BRAKE
  logic [SW-1:0] step_cnt, step_cnt_d;
  logic [7:0]    pos_d;
  logic          exit_req, exit_to_dead;
  logic          in_a_d, in_b_d, busy_d, fault_d, limit_closed_d, limit_open_d;
  logic          new_dir;
`ifdef DOOR_MOTOR_BRAKE_EN
  logic          brake_to_dead, brake_to_dead_d;
`endif

  // State, command and registered outputs; reset assumes the door is closed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cmd_q        <= 2'b00;
      dir          <= 1'b0;
      dead_cnt     <= '0;
      step_cnt     <= '0;
      pos          <= 8'd0;
      in_a         <= 1'b0;
      in_b         <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      limit_closed <= 1'b1;
      limit_open   <= 1'b0;
`ifdef DOOR_MOTOR_BRAKE_EN
      brake_to_dead <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      cmd_q        <= motor_cmd;
      dir          <= dir_d;
      dead_cnt     <= dead_cnt_d;
      step_cnt     <= step_cnt_d;
      pos          <= pos_d;
      in_a         <= in_a_d;
      in_b         <= in_b_d;
      busy         <= busy_d;
      fault        <= fault_d;
      limit_closed <= limit_closed_d;
      limit_open   <= limit_open_d;
`ifdef DOOR_MOTOR_BRAKE_EN
      brake_to_dead <= brake_to_dead_d;
`endif
    end
  end

  // Next state, position and counters; a limit reached beats a same-cycle stop or reversal
  always_comb begin
    state_d      = state;
    pos_d        = pos;
    dir_d        = dir;
    dead_cnt_d   = '0;
    step_cnt_d   = '0;
    exit_req     = 1'b0;
    exit_to_dead = 1'b0;
    new_dir      = (cmd_q == 2'b01);
`ifdef DOOR_MOTOR_BRAKE_EN
    brake_to_dead_d = brake_to_dead;
`endif
    case (state)
      S_IDLE: begin
        if (cmd_q == 2'b11) begin
          state_d = S_FAULT;
        end else if (cmd_q == 2'b01 && pos != POS_MAX) begin
          state_d = S_DEAD;
          dir_d   = 1'b1;
        end else if (cmd_q == 2'b10 && pos != 8'd0) begin
          state_d = S_DEAD;
          dir_d   = 1'b0;
        end
      end
      S_DEAD: begin
        if (cmd_q == 2'b11) begin
          state_d = S_FAULT;
        end else if (cmd_q == 2'b00) begin
          state_d = S_IDLE;
        end else if (new_dir != dir) begin
          // Retarget; nothing to do if the new direction is already at its limit
          if ((new_dir && pos == POS_MAX) || (!new_dir && pos == 8'd0)) begin
            state_d = S_IDLE;
          end else begin
            dir_d = new_dir;
          end
        end else if (dead_cnt == DEAD_LAST) begin
          state_d = dir ? S_DRIVE_OPEN : S_DRIVE_CLOSE;
        end else begin
          dead_cnt_d = dead_cnt + 1'b1;
        end
      end
      S_DRIVE_OPEN: begin
        if (cmd_q == 2'b11) begin
          state_d = S_FAULT;
        end else if (step_cnt == STEP_LAST && pos >= POS_MAX - 8'd1) begin
          pos_d    = POS_MAX;
          exit_req = 1'b1;
        end else if (cmd_q == 2'b00) begin
          exit_req = 1'b1;
        end else if (cmd_q == 2'b10) begin
          exit_req     = 1'b1;
          exit_to_dead = (pos != 8'd0);
          dir_d        = 1'b0;
        end else if (step_cnt == STEP_LAST) begin
          pos_d = pos + 8'd1;
        end else begin
          step_cnt_d = step_cnt + 1'b1;
        end
      end
      S_DRIVE_CLOSE: begin
        if (cmd_q == 2'b11) begin
          state_d = S_FAULT;
        end else if (step_cnt == STEP_LAST && pos <= 8'd1) begin
          pos_d    = 8'd0;
          exit_req = 1'b1;
        end else if (cmd_q == 2'b00) begin
          exit_req = 1'b1;
        end else if (cmd_q == 2'b01) begin
          exit_req     = 1'b1;
          exit_to_dead = (pos != POS_MAX);
          dir_d        = 1'b1;
        end else if (step_cnt == STEP_LAST) begin
          pos_d = pos - 8'd1;
        end else begin
          step_cnt_d = step_cnt + 1'b1;
        end
      end
`ifdef DOOR_MOTOR_BRAKE_EN
      S_BRAKE: begin
        if (cmd_q == 2'b11) begin
          state_d = S_FAULT;
        end else if (dead_cnt == DEAD_LAST) begin
          state_d = brake_to_dead ? S_DEAD : S_IDLE;
        end else begin
          dead_cnt_d = dead_cnt + 1'b1;
        end
      end
`endif
      S_FAULT: begin
        if (cmd_q == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (exit_req) begin
`ifdef DOOR_MOTOR_BRAKE_EN
      state_d         = S_BRAKE;
      brake_to_dead_d = exit_to_dead;
`else
      state_d = exit_to_dead ? S_DEAD : S_IDLE;
`endif
    end
  end

  // Output values decoded from the next state so they register on the same edge as the state
  always_comb begin
    in_a_d         = (state_d == S_DRIVE_OPEN);
    in_b_d         = (state_d == S_DRIVE_CLOSE);
    busy_d         = (state_d == S_DEAD) || (state_d == S_DRIVE_OPEN) || (state_d == S_DRIVE_CLOSE);
    fault_d        = (state_d == S_FAULT);
    limit_closed_d = (pos_d == 8'd0);
    limit_open_d   = (pos_d == POS_MAX);
`ifdef DOOR_MOTOR_BRAKE_EN
    if (state_d == S_BRAKE) begin
      in_a_d = 1'b1;
      in_b_d = 1'b1;
      busy_d = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_door_motor_driver.sv
// tb/tb_door_motor_driver.sv - directed bench for door_motor_driver (STEP_DIV=4, TRAVEL=5, DEAD_CYCLES=3)
module tb_door_motor_driver;

  logic       clk;
  logic       rst;
  logic [1:0] cmd;
  logic       in_a, in_b, limit_closed, limit_open, busy, fault;
  logic [7:0] pos;
  int         checks;
  int         errors;
  logic       found;

  door_motor_driver #(.STEP_DIV(4), .TRAVEL(5), .DEAD_CYCLES(3)) dut (
    .clk(clk),
    .rst(rst),
    .motor_cmd(cmd),
    .in_a(in_a),
    .in_b(in_b),
    .pos(pos),
    .limit_closed(limit_closed),
    .limit_open(limit_open),
    .busy(busy),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
`ifndef DOOR_MOTOR_BRAKE_EN
    check("excl", {31'd0, in_a & in_b}, 0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    cmd    = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pos", pos, 0);
    check("rst_lc", limit_closed, 1);
    check("rst_lo", limit_open, 0);
    check("rst_a", in_a, 0);
    check("rst_b", in_b, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;

    // Close while already closed does nothing
    cmd = 2'b10;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t1_busy", busy, 0);
      check("t1_b", in_b, 0);
    end
    check("t1_pos", pos, 0);
    check("t1_lc", limit_closed, 1);
    cmd = 2'b00;
    tick();

`ifdef DOOR_MOTOR_BRAKE_EN
    // Stop during open at pos 2 brakes for 3 cycles
    cmd = 2'b01;
    repeat (4) tick();
    tick();
    check("t6_a_drive", in_a, 1);
    check("t6_b_drive", in_b, 0);
    repeat (7) tick();
    tick();
    check("t6_pos2", pos, 2);
    cmd = 2'b00;
    tick();
    check("t6_a_e1", in_a, 1);
    check("t6_b_e1", in_b, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_brk_a", in_a, 1);
      check("t6_brk_b", in_b, 1);
      check("t6_brk_busy", busy, 1);
    end
    tick();
    check("t6_end_a", in_a, 0);
    check("t6_end_b", in_b, 0);
    check("t6_end_busy", busy, 0);
    check("t6_end_pos", pos, 2);
`else
    // Full open
    cmd = 2'b01;
    tick();
    check("t2_busy_e1", busy, 0);
    tick();
    check("t2_busy_e2", busy, 1);
    check("t2_a_dead", in_a, 0);
    repeat (2) begin
      tick();
      check("t2_a_dead", in_a, 0);
    end
    tick();
    check("t2_a_drive", in_a, 1);
    check("t2_pos0", pos, 0);
    for (int k = 1; k <= 5; k++) begin
      repeat (3) begin
        tick();
        check("t2_pos_hold", pos, k - 1);
        check("t2_a_on", in_a, 1);
      end
      tick();
      check("t2_pos_step", pos, k);
    end
    check("t2_a_lim", in_a, 0);
    check("t2_lo", limit_open, 1);
    check("t2_lc", limit_closed, 0);
    check("t2_busy_lim", busy, 0);
    repeat (5) begin
      tick();
      check("t2_hold_a", in_a, 0);
      check("t2_hold_busy", busy, 0);
    end

    // Close to 3 then reverse back to 5
    cmd = 2'b10;
    tick();
    check("t3_b_e1", in_b, 0);
    tick();
    check("t3_busy", busy, 1);
    check("t3_b_dead", in_b, 0);
    repeat (2) tick();
    tick();
    check("t3_b_drive", in_b, 1);
    for (int k = 4; k >= 3; k--) begin
      repeat (3) begin
        tick();
        check("t3_pos_hold", pos, k + 1);
      end
      tick();
      check("t3_pos_step", pos, k);
    end
    check("t3_lo_off", limit_open, 0);
    cmd = 2'b01;
    tick();
    check("t3_b_still", in_b, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_rev_a", in_a, 0);
      check("t3_rev_b", in_b, 0);
      check("t3_rev_busy", busy, 1);
    end
    tick();
    check("t3_a_drive", in_a, 1);
    check("t3_pos3", pos, 3);
    for (int k = 4; k <= 5; k++) begin
      repeat (3) tick();
      tick();
      check("t3_pos_up", pos, k);
    end
    check("t3_a_lim", in_a, 0);
    check("t3_lo", limit_open, 1);

    // Invalid command during close
    cmd = 2'b10;
    repeat (4) tick();
    tick();
    check("t4_b_drive", in_b, 1);
    repeat (3) tick();
    tick();
    check("t4_pos4", pos, 4);
    tick();
    cmd = 2'b11;
    tick();
    check("t4_b_e1", in_b, 1);
    check("t4_fault_e1", fault, 0);
    tick();
    check("t4_b_off", in_b, 0);
    check("t4_fault", fault, 1);
    check("t4_busy", busy, 0);
    check("t4_pos_held", pos, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_fault_hold", fault, 1);
      check("t4_pos_hold", pos, 4);
    end
    cmd = 2'b00;
    tick();
    check("t4_fault_e1b", fault, 1);
    tick();
    check("t4_fault_clr", fault, 0);
    check("t4_busy_clr", busy, 0);
    check("t4_pos_end", pos, 4);
`endif

    // Async reset mid-drive at pos 2
    cmd   = 2'b10;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pos == 8'd2 && in_b == 1'b1) found = 1'b1;
    end
    check("t5_reach", found, 1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t5_pos", pos, 0);
    check("t5_b", in_b, 0);
    check("t5_a", in_a, 0);
    check("t5_lc", limit_closed, 1);
    check("t5_lo", limit_open, 0);
    check("t5_busy", busy, 0);
    cmd = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    check("t5_after_busy", busy, 0);
    check("t5_after_pos", pos, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
